// File: rtl/multi_channel_debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM state encoding and counter terminal helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_pkg;

    // Per-channel FSM state encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        ACTIVE  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Largest value a counter of the given width can hold (2^width - 1)
    function automatic int unsigned terminalCount(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/multi_channel_debounce_if.sv
// Bundle of per-channel raw inputs, configuration and debounced results.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/strobe, no handshake.
// master: drives inputs/activeLowMask/filterEnable, observes results.
// slave : the debouncer; consumes inputs/config, drives results.
interface multi_channel_debounce_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] inputs;
    logic [CHANNELS-1:0] activeLowMask;
    logic [CHANNELS-1:0] filterEnable;
    logic [CHANNELS-1:0] debounced;
    logic [CHANNELS-1:0] assertStrobe;
    logic [CHANNELS-1:0] releaseStrobe;
    logic                anyActive;

    modport master (
        output inputs, activeLowMask, filterEnable,
        input  debounced, assertStrobe, releaseStrobe, anyActive
    );

    modport slave (
        input  inputs, activeLowMask, filterEnable,
        output debounced, assertStrobe, releaseStrobe, anyActive
    );
endinterface

// File: rtl/multi_channel_debounce_channel.sv
// One debouncer channel: polarity normalisation, synchroniser, optional qualification, pulse stretcher, strobes.
// Latency: SYNC_STAGES+1 cycles raw-to-debounced (filter off); +2^FILTER_COUNTER_WIDTH with filter on.
// Backpressure: none; free-running, outputs are registered levels/strobes.
// Ports: clk, resetN (async active-low), raw input, active_low polarity, filter_en,
//        debounced level, assert_strobe / release_strobe one-cycle pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int HIGH_COUNTER_WIDTH   = 6,
    parameter int FILTER_COUNTER_WIDTH = 3,
    parameter int SYNC_STAGES          = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic raw,
    input  logic active_low,
    input  logic filter_en,
    output logic debounced,
    output logic assert_strobe,
    output logic release_strobe
);

    // Qualification ends when the filter counter hits its terminal value.
    localparam logic [FILTER_COUNTER_WIDTH-1:0] FILT_LAST =
        FILTER_COUNTER_WIDTH'(terminalCount(FILTER_COUNTER_WIDTH));
    // HOLD is entered with the counter at 0, so stopping one short of the
    // terminal value gives a tail of exactly 2^HIGH_COUNTER_WIDTH-1 cycles.
    localparam logic [HIGH_COUNTER_WIDTH-1:0] HOLD_LAST =
        HIGH_COUNTER_WIDTH'(terminalCount(HIGH_COUNTER_WIDTH) - 1);

    logic [SYNC_STAGES-1:0]          sync;
    logic                            act_s;
    state_t                          state;
    logic [FILTER_COUNTER_WIDTH-1:0] filt_cnt;
    logic [HIGH_COUNTER_WIDTH-1:0]   hold_cnt;

    // Polarity is folded in before the first flop so the whole chain is active-high.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw ^ active_low};
        end
    end

    assign act_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            filt_cnt       <= '0;
            hold_cnt       <= '0;
            debounced      <= 1'b0;
            assert_strobe  <= 1'b0;
            release_strobe <= 1'b0;
        end else begin
            assert_strobe  <= 1'b0;
            release_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (act_s) begin
                        if (filter_en) begin
                            state    <= QUALIFY;
                            filt_cnt <= '0;
                        end else begin
                            state         <= ACTIVE;
                            debounced     <= 1'b1;
                            assert_strobe <= 1'b1;
                        end
                    end
                end
                QUALIFY: begin
                    if (filt_cnt == FILT_LAST) begin
                        // The window is complete; the input may already have
                        // dropped this cycle, in which case the tail starts now.
                        debounced     <= 1'b1;
                        assert_strobe <= 1'b1;
                        if (act_s) begin
                            state <= ACTIVE;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end else if (!act_s) begin
                        state <= IDLE;
                    end else begin
                        filt_cnt <= filt_cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!act_s) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (act_s) begin
                        // Bounce during the tail: merge into the same pulse.
                        state <= ACTIVE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state          <= IDLE;
                        debounced      <= 1'b0;
                        release_strobe <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_channel_debounce.sv
// N independent debounce/stretch channels plus a registered any-active flag.
// Latency: SYNC_STAGES+1 cycles to debounced; anyActive one cycle after debounced.
// Backpressure: none; free-running.
// Ports: clk, resetN (async active-low), bus (slave modport: inputs, activeLowMask,
//        filterEnable in; debounced, assertStrobe, releaseStrobe, anyActive out).
module multi_channel_debounce
    import debounce_pkg::*;
#(
    parameter int CHANNELS             = 4,
    parameter int HIGH_COUNTER_WIDTH   = 6,
    parameter int FILTER_COUNTER_WIDTH = 3,
    parameter int SYNC_STAGES          = 2
) (
    input  logic                    clk,
    input  logic                    resetN,
    multi_channel_debounce_if.slave bus
);

    logic [CHANNELS-1:0] deb_v;
    logic [CHANNELS-1:0] assert_v;
    logic [CHANNELS-1:0] release_v;
    logic                any_active;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .HIGH_COUNTER_WIDTH  (HIGH_COUNTER_WIDTH),
            .FILTER_COUNTER_WIDTH(FILTER_COUNTER_WIDTH),
            .SYNC_STAGES         (SYNC_STAGES)
        ) u_ch (
            .clk           (clk),
            .resetN        (resetN),
            .raw           (bus.inputs[i]),
            .active_low    (bus.activeLowMask[i]),
            .filter_en     (bus.filterEnable[i]),
            .debounced     (deb_v[i]),
            .assert_strobe (assert_v[i]),
            .release_strobe(release_v[i])
        );
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            any_active <= 1'b0;
        end else begin
            any_active <= |deb_v;
        end
    end

    assign bus.debounced     = deb_v;
    assign bus.assertStrobe  = assert_v;
    assign bus.releaseStrobe = release_v;
    assign bus.anyActive     = any_active;

endmodule

// File: doc/multi_channel_debounce.md
Name: multi_channel_debounce

Overview:
- Per-channel debouncer and pulse stretcher for asynchronous front-panel and trigger inputs.
- Generalises the single-channel falling-edge debouncer in four ways:
  - N channels.
  - Per-channel input polarity.
  - Configurable synchroniser depth.
  - Optional per-channel glitch-qualification filter.
- Also adds assert/release strobes per channel and a combined any-active flag.
- Sits between FPGA input pins and the event/trigger logic.

Parameters:
- CHANNELS, 4, number of independent channels.
- HIGH_COUNTER_WIDTH, 6, stretch counter width; the hold tail is 2^HIGH_COUNTER_WIDTH−1 cycles; legal range ≥2.
- FILTER_COUNTER_WIDTH, 3, qualification window is 2^FILTER_COUNTER_WIDTH consecutive cycles; legal range ≥1.
- SYNC_STAGES, 2, synchroniser flop depth; legal range ≥2.

Ports:
- clk  in  1  single system clock.
- resetN  in  1  asynchronous, active-low reset.
- inputs  in  CHANNELS  raw asynchronous inputs.
- activeLowMask  in  CHANNELS  per-channel polarity; 1 = input active when low. Quasi-static.
- filterEnable  in  CHANNELS  per-channel enable for glitch qualification. Quasi-static.
- debounced  out  CHANNELS  stretched, active-high result.
- assertStrobe  out  CHANNELS  one-cycle pulse on the first high cycle of debounced.
- releaseStrobe  out  CHANNELS  one-cycle pulse on the first low cycle after debounced falls.
- anyActive  out  1  registered OR of all debounced bits.

Behaviour:
- Reset is asynchronous, active-low, one clock domain. While resetN=0:
  - All outputs are 0.
  - Sync flops, FSMs and counters are cleared to 0 / IDLE.
  - Reset asserted mid-pulse drops debounced immediately; no releaseStrobe is emitted for that pulse.
- Normalisation: act = inputs XOR activeLowMask, then SYNC_STAGES flops → actS.
  - Changing the mask is allowed only while the channel is IDLE. A mask-change edge is treated as ordinary input.
- Channels are fully independent. Each runs its own FSM with states IDLE, QUALIFY, ACTIVE, HOLD.
- IDLE (debounced=0):
  - filterEnable is sampled here only.
  - If actS=1 and the filter is off → ACTIVE.
  - If actS=1 and the filter is on → QUALIFY, with filtCnt cleared.
- QUALIFY (debounced=0):
  - actS=0 → IDLE (glitch rejected, no strobes).
  - actS=1 for 2^FILTER_COUNTER_WIDTH consecutive cycles → ACTIVE.
- ACTIVE (debounced=1): stay while actS=1; on actS=0 → HOLD with holdCnt cleared.
- HOLD (debounced=1):
  - actS=1 → ACTIVE (retrigger; counter restarts; no strobes).
  - Otherwise count; exit to IDLE so that the tail timing below holds exactly.
- Timing, filter off. Let t0 = first cycle actS=1 and L = consecutive actS-high cycles.
  - debounced is high from t0+1 through t0+L+2^HIGH_COUNTER_WIDTH−1 inclusive.
  - Pulse width is exactly L+2^HIGH_COUNTER_WIDTH−1 cycles.
  - Raw-input-to-output latency is SYNC_STAGES+1 cycles.
- Timing, filter on:
  - If L<2^FILTER_COUNTER_WIDTH: no output and no strobes.
  - Otherwise debounced rises at t0+2^FILTER_COUNTER_WIDTH+1. The fall is identical to the filter-off case.
- Bounce handling: any number of active bursts separated by fewer than 2^HIGH_COUNTER_WIDTH−1 inactive cycles merges into one pulse, with one assertStrobe and one releaseStrobe.
- Strobes are registered and aligned to the debounced transitions. Both strobes are never high in the same cycle.
- anyActive is the registered OR of the debounced bits, one cycle later.
- Counter widths are exactly as parameterised. Counters never wrap, because each state exits at its terminal count.

Decomposition:
- debounce_pkg holds:
  - State encoding localparams (IDLE=0, QUALIFY=1, ACTIVE=2, HOLD=3).
  - Function terminalCount(width) returning 2^width−1.
- One sub-module, debounce_channel, contains sync, FSM, counters and strobes. It is instantiated CHANNELS times via generate.
- The top level adds only the anyActive register.

Test Plan:
Defaults apply: CHANNELS=4, HIGH=6, FILTER=3, SYNC=2. t0 = first actS-high cycle.
1. Ch0, active-low, filter off, input low 1 cycle → debounced high 64 cycles, rising 3 clocks after the input falls. assertStrobe is 1 cycle at the rise; releaseStrobe is 1 cycle at the fall.
2. Ch0, input low 10 cycles → debounced high 73 cycles. Other channels stay 0. anyActive follows one cycle late.
3. Ch1, active-high, filter on:
   - 7-cycle pulse → no output, no strobes.
   - 20-cycle pulse → rise at t0+9, fall at t0+84 (75 cycles high).
4. Ch2, active-low, 1-cycle low pulses at t0 and t0+30 → single interval from t0+1 to t0+94, exactly one assertStrobe and one releaseStrobe.
5. All four channels pulsed in the same cycle with different lengths (1, 5, 10, 40) → independent widths 64, 68, 73, 103. anyActive is high from first rise to last fall +1.
6. resetN pulled low during ch0 HOLD → debounced is 0 asynchronously with no releaseStrobe. After release with the input idle, outputs stay 0 for 200 cycles.
